// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;
    localparam int KEY_W    = ROW_W + COL_W;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // Active-low one-hot row drive for a row index.
    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_W-1:0] idx);
        return ~(NUM_ROWS'(1) << idx);
    endfunction

    // Index of the lowest-numbered column reading low (0 if none).
    function automatic logic [COL_W-1:0] lowest_low(input logic [NUM_COLS-1:0] col);
        logic [COL_W-1:0] r;
        r = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!col[i]) r = COL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles from input change to output change.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two-stage capture; resets to all ones so an idle (pulled-up) bus reads idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a one-entry valid/ready key output.
// Latency: 2-cycle COL sync, then DEBOUNCE_CYC stable cycles; key_valid one cycle after accept.
// Backpressure: a key pushed while key_valid && !key_ready is dropped and overflow pulses.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_ROWS-1:0] ROW,
    input  logic [NUM_COLS-1:0] COL,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_down,
    output logic                overflow
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

    state_t              r_state;
    logic [ROW_W-1:0]    r_row_idx;
    logic [NUM_ROWS-1:0] r_row;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [DB_W-1:0]     r_db_cnt;
    logic [COL_W-1:0]    r_cand_col;
    logic                r_key_down;
    logic [KEY_W-1:0]    r_key_code;
    logic                r_key_valid;
    logic                r_overflow;

    logic [NUM_COLS-1:0] w_col_s;
    logic [ROW_W-1:0]    w_row_next;
    logic                w_tick;
    logic                w_cand_low;
    logic                w_push;
    logic [KEY_W-1:0]    w_push_code;

    sync_2ff #(.W(NUM_COLS)) u_col_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (COL),
        .o_q   (w_col_s)
    );

    assign w_row_next  = r_row_idx + 2'd1;
    assign w_tick      = (r_state == ST_SCAN) && (r_scan_cnt == SCAN_LAST);
    assign w_cand_low  = !w_col_s[r_cand_col];
    assign w_push      = (r_state == ST_DEBOUNCE) && w_cand_low && (r_db_cnt == DB_LAST);
    assign w_push_code = {r_row_idx, r_cand_col};

    // Scan / debounce / held state machine; the row stays frozen outside SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= '0;
            r_row      <= 4'b1110;
            r_scan_cnt <= '0;
            r_db_cnt   <= '0;
            r_cand_col <= '0;
            r_key_down <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_tick) begin
                        r_scan_cnt <= '0;
                        if (w_col_s != 4'hF) begin
                            r_cand_col <= lowest_low(w_col_s);
                            r_db_cnt   <= '0;
                            r_state    <= ST_DEBOUNCE;
                        end else begin
                            r_row_idx <= w_row_next;
                            r_row     <= row_drive(w_row_next);
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_cand_low) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_db_cnt   <= '0;
                            r_key_down <= 1'b1;
                            r_state    <= ST_HELD;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: give up on this candidate and move on.
                        r_row_idx  <= w_row_next;
                        r_row      <= row_drive(w_row_next);
                        r_scan_cnt <= '0;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (!w_cand_low) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_db_cnt   <= '0;
                            r_key_down <= 1'b0;
                            r_row_idx  <= w_row_next;
                            r_row      <= row_drive(w_row_next);
                            r_scan_cnt <= '0;
                            r_state    <= ST_SCAN;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end else begin
                        // Any low reading restarts the release window.
                        r_db_cnt <= '0;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    // One-entry output register: load on push unless a stale key is still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (w_push) begin
                if (!r_key_valid || key_ready) begin
                    r_key_code  <= w_push_code;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign ROW       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and key scoreboard.
// Latency: n/a.
// Backpressure: drives key_ready low in the overflow scenario.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_down;
    logic       overflow;

    logic [15:0] pressed = '0;
    logic [3:0]  row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int ovs    = 0;
    logic [3:0] exp_q [$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ROW       (ROW),
        .COL       (COL),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !ROW[r]) COL[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_down(input logic v, input int bound, input string tag);
        for (int i = 0; i < bound && key_down !== v; i++) @(negedge clk);
        chk(tag, 32'(key_down), 32'(v));
    endtask

    task automatic wait_xfers(input int target, input int bound, input string tag);
        for (int i = 0; i < bound && xfers < target; i++) @(negedge clk);
        chk(tag, 32'(xfers), 32'(target));
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected key.
    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovs++;
            if (key_valid && key_ready) begin
                xfers++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected: observed=%0h expected=none", key_code);
                end
                if (exp_q.size() != 0) chk("sb_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int x0;
        int o0;

        // Reset state
        cyc(2);
        chk("rst_row", 32'(ROW), 32'h E);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_down", 32'(key_down), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // Idle row rotation
        for (int k = 1; k <= 5; k++) begin
            cyc(SD);
            chk("idle_row", 32'(ROW), 32'(row_seq[k % 4]));
            chk("idle_valid", 32'(key_valid), 0);
        end

        // Key 9 (row 2, col 1) held for 40 cycles
        x0 = xfers;
        exp_q.push_back(4'd9);
        pressed[9] = 1'b1;
        cyc(40);
        chk("k9_one_push", 32'(xfers), 32'(x0 + 1));
        chk("k9_down", 32'(key_down), 1);
        chk("k9_row_frozen", 32'(ROW), 32'h B);
        pressed[9] = 1'b0;
        cyc(9);
        chk("k9_down_hold", 32'(key_down), 1);
        cyc(1);
        chk("k9_down_fall", 32'(key_down), 0);
        chk("k9_no_repeat", 32'(xfers), 32'(x0 + 1));

        // Key 7 (row 1, col 3) bounce then steady press
        x0 = xfers;
        for (int b = 0; b < 8; b++) begin
            pressed[7] = 1'b1;
            cyc(3);
            pressed[7] = 1'b0;
            cyc(1);
        end
        chk("k7_bounce_nopush", 32'(xfers), 32'(x0));
        chk("k7_bounce_nodown", 32'(key_down), 0);
        exp_q.push_back(4'd7);
        pressed[7] = 1'b1;
        wait_xfers(x0 + 1, 100, "k7_push");
        chk("k7_row_frozen", 32'(ROW), 32'h D);
        pressed[7] = 1'b0;
        wait_down(1'b0, 40, "k7_release");

        // Backpressure: key 0 retained, key 15 dropped
        key_ready = 1'b0;
        x0 = xfers;
        o0 = ovs;
        exp_q.push_back(4'd0);
        pressed[0] = 1'b1;
        for (int i = 0; i < 80 && !key_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(key_valid), 1);
        chk("bp_code0", 32'(key_code), 0);
        pressed[0] = 1'b0;
        wait_down(1'b0, 40, "bp_k0_release");
        pressed[15] = 1'b1;
        for (int i = 0; i < 80 && ovs == o0; i++) @(negedge clk);
        chk("bp_ovf_seen", 32'(ovs), 32'(o0 + 1));
        chk("bp_code_kept", 32'(key_code), 0);
        chk("bp_valid_kept", 32'(key_valid), 1);
        pressed[15] = 1'b0;
        wait_down(1'b0, 40, "bp_k15_release");
        cyc(5);
        chk("bp_ovf_once", 32'(ovs), 32'(o0 + 1));
        chk("bp_no_xfer", 32'(xfers), 32'(x0));
        key_ready = 1'b1;
        cyc(2);
        chk("bp_drain", 32'(xfers), 32'(x0 + 1));
        chk("bp_valid_clr", 32'(key_valid), 0);

        // Simultaneous row 0 col 2 + col 3, then row 3 press while frozen
        x0 = xfers;
        exp_q.push_back(4'd2);
        pressed[2] = 1'b1;
        pressed[3] = 1'b1;
        wait_down(1'b1, 60, "sim_down");
        wait_xfers(x0 + 1, 10, "sim_push");
        pressed[15] = 1'b1;
        cyc(30);
        chk("sim_ignore_row3", 32'(xfers), 32'(x0 + 1));
        chk("sim_row_frozen", 32'(ROW), 32'h E);
        chk("sim_code", 32'(key_code), 2);
        exp_q.push_back(4'd15);
        pressed[2] = 1'b0;
        pressed[3] = 1'b0;
        wait_xfers(x0 + 2, 120, "sim_k15_push");
        pressed[15] = 1'b0;
        wait_down(1'b0, 40, "sim_k15_release");

        // Reset mid-DEBOUNCE on key 12 (row 3, col 0)
        x0 = xfers;
        pressed[12] = 1'b1;
        for (int i = 0; i < 40 && ROW !== 4'b0111; i++) @(negedge clk);
        chk("rd_row3", 32'(ROW), 32'h7);
        cyc(6);
        chk("rd_frozen", 32'(ROW), 32'h7);
        rst = 1'b1;
        pressed[12] = 1'b0;
        cyc(2);
        chk("rd_row", 32'(ROW), 32'h E);
        chk("rd_valid", 32'(key_valid), 0);
        chk("rd_down", 32'(key_down), 0);
        rst = 1'b0;
        cyc(30);
        chk("rd_no_push", 32'(xfers), 32'(x0));
        chk("rd_valid_after", 32'(key_valid), 0);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
